control_pipe: RTL

- Parametrised, registered successor to the combinational MIPS control decoder.
- Decodes the group R-format (ADD/SUB/AND/OR/MULT), LW and SW into the 12-bit control word.
- Registers the control word at issue and tracks in-flight writebacks in a scoreboard.
- Interlocks on RAW hazards and holds issue for multi-cycle MULT. Sits between instruction fetch and the register file/ALU datapath.

---
 rtl/control_pipe.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/control_pipe.sv
// Registered MIPS control decoder with a writeback scoreboard, RAW interlock and MULT issue hold.
// The control word is {c_sel, d_sel, op_sel[1:0], rd_wr, wb_sel, wb_en, wb_reg[4:0]}.
module control_pipe #(
    parameter int GRUPO       = 7,
    parameter int SHAMT_TAG   = 10,
    parameter int PIPE_DEPTH  = 4,
    parameter int MULT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        stall,
    output logic [4:0]  a_reg,
    output logic [4:0]  b_reg,
    output logic [11:0] ctrl,
    output logic        ctrl_valid,
    output logic        retire_en,
    output logic [4:0]  retire_reg
);

    typedef struct packed {
        logic       c_sel;
        logic       d_sel;
        logic [1:0] op_sel;
        logic       rd_wr;
        logic       wb_sel;
        logic       wb_en;
        logic [4:0] wb_reg;
    } ctrl_t;

    localparam logic [5:0]  OP_R     = 6'(GRUPO);
    localparam logic [5:0]  OP_LW    = 6'(GRUPO + 1);
    localparam logic [5:0]  OP_SW    = 6'(GRUPO + 2);
    localparam logic [4:0]  SHAMT    = 5'(SHAMT_TAG);
    localparam logic [11:0] NOP_CTRL = 12'hF00;
    localparam int          BW       = $clog2(MULT_CYCLES + 1);
    localparam logic [BW-1:0] BUSY_LOAD = BW'(MULT_CYCLES - 1);

    logic [5:0] opcode, funct;
    logic [4:0] rs, rt, rd, shamt;

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];

    ctrl_t      dec;
    logic [4:0] dec_a, dec_b;
    logic       use_a, use_b, is_mult;

    // NOTE: every variable driven here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        dec     = ctrl_t'(NOP_CTRL);
        dec_a   = '0;
        dec_b   = '0;
        use_a   = 1'b0;
        use_b   = 1'b0;
        is_mult = 1'b0;
        if (opcode == OP_R && shamt == SHAMT) begin
            dec_a      = rs;
            dec_b      = rt;
            use_a      = 1'b1;
            use_b      = 1'b1;
            dec.c_sel  = 1'b0;
            dec.wb_en  = 1'b1;
            dec.wb_reg = rd;
            case (funct)
                6'd32:   dec.op_sel = 2'd0;
                6'd34:   dec.op_sel = 2'd1;
                6'd36:   dec.op_sel = 2'd2;
                6'd50: begin
                    dec.d_sel  = 1'b0;
                    dec.op_sel = 2'd0;
                    is_mult    = 1'b1;
                end
                default: dec.op_sel = 2'd3;
            endcase
        end else if (opcode == OP_LW) begin
            dec_a      = rs;
            use_a      = 1'b1;
            dec.op_sel = 2'd0;
            dec.wb_sel = 1'b1;
            dec.wb_en  = 1'b1;
            dec.wb_reg = rt;
        end else if (opcode == OP_SW) begin
            dec_a      = rs;
            dec_b      = rt;
            use_a      = 1'b1;
            use_b      = 1'b1;
            dec.op_sel = 2'd0;
            dec.rd_wr  = 1'b1;
            dec.wb_sel = 1'b1;
        end
    end

    logic [PIPE_DEPTH-1:0] sb_valid;
    logic [4:0]            sb_reg [PIPE_DEPTH];
    logic [BW-1:0]         busy;
    logic                  hazard, accept, sb_load;

    // The last entry still blocks: its register write lands only at the end of the retire cycle.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            if (sb_valid[i] &&
                ((use_a && dec_a != 5'd0 && sb_reg[i] == dec_a) ||
                 (use_b && dec_b != 5'd0 && sb_reg[i] == dec_b)))
                hazard = 1'b1;
        end
    end

    assign stall   = hazard | (busy != '0);
    assign accept  = instr_valid & ~stall;
    assign sb_load = accept & dec.wb_en & (dec.wb_reg != 5'd0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the scoreboard is a small shift register, not a RAM, so it is cleared on reset
            // to discard all in-flight tracking.
            sb_valid   <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) sb_reg[i] <= '0;
            busy       <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            ctrl       <= NOP_CTRL;
            ctrl_valid <= 1'b0;
        end else begin
            if (accept) begin
                a_reg      <= dec_a;
                b_reg      <= dec_b;
                ctrl       <= dec;
                ctrl_valid <= 1'b1;
            end else begin
                a_reg      <= '0;
                b_reg      <= '0;
                ctrl       <= NOP_CTRL;
                ctrl_valid <= 1'b0;
            end

            for (int i = PIPE_DEPTH - 1; i > 0; i--) begin
                sb_valid[i] <= sb_valid[i-1];
                sb_reg[i]   <= sb_reg[i-1];
            end
            sb_valid[0] <= sb_load;
            sb_reg[0]   <= sb_load ? dec.wb_reg : 5'd0;

            if (accept && is_mult)
                busy <= BUSY_LOAD;
            else if (busy != '0)
                busy <= busy - 1'b1;
        end
    end

    assign retire_en  = sb_valid[PIPE_DEPTH-1];
    assign retire_reg = sb_reg[PIPE_DEPTH-1];

endmodule
